// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the regfile write-port arbiter.
//   req_valid/req_ready : per-requester handshake (one-hot ready)
//   req_addr/req_data   : per-requester destination register and write data
//   rd_en/rd_addr/rd_data : registered regfile write port
// Modports: master = requester/regfile side, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 2
);
    localparam int AW = 5;
    localparam int DW = 32;

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_data;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic [DW-1:0]           rd_data;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rd_en, rd_addr, rd_data
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rd_en, rd_addr, rd_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter owning the regfile's single write port.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wb (slave)       requester handshake in, registered regfile write port out
//   issue_en_i/issue_addr_i  decode issued an instr writing issue_addr_i
//   flush_i          clears all pending bits
//   rs1/rs2_addr_i   decode source registers
//   rs1/rs2_busy_o   source has a pending write (combinational)
// Optional feature macro: WB_SCOREBOARD_EN builds the pending-write
// scoreboard; without it the busy outputs are tied low.
module regfile_wb_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave wb,
    input  logic                issue_en_i,
    input  logic [4:0]          issue_addr_i,
    input  logic                flush_i,
    input  logic [4:0]          rs1_addr_i,
    input  logic [4:0]          rs2_addr_i,
    output logic                rs1_busy_o,
    output logic                rs2_busy_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rd_en_q, rd_en_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;

    // Scan from ptr+1 (wrapping) and grant the first valid requester.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int            j;
            logic [PW-1:0] jj;
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = PW'(j);
            if (!gnt_any && wb.req_valid[jj]) begin
                grant[jj] = 1'b1;
                gnt_idx   = jj;
                gnt_any   = 1'b1;
            end
        end
    end

    // Ready is suppressed while reset is asserted.
    assign wb.req_ready = grant & {NREQ{rst_n}};

    always_comb begin
        ptr_d     = ptr_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (gnt_any) begin
            ptr_d     = gnt_idx;
            rd_addr_d = wb.req_addr[gnt_idx];
            rd_data_d = wb.req_data[gnt_idx];
            // x0 writes complete the handshake but never reach the regfile
            rd_en_d   = (wb.req_addr[gnt_idx] != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= PW'(NREQ - 1);
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign wb.rd_en   = rd_en_q;
    assign wb.rd_addr = rd_addr_q;
    assign wb.rd_data = rd_data_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] pend_q, pend_d;

    // Order matters: commit clears, flush wipes, then a new issue sets, so a
    // same-edge issue always wins over both clear and flush.
    always_comb begin
        pend_d = pend_q;
        if (rd_en_q) pend_d[rd_addr_q] = 1'b0;
        if (flush_i) pend_d = '0;
        if (issue_en_i && issue_addr_i != 5'd0) pend_d[issue_addr_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign rs1_busy_o = pend_q[rs1_addr_i];
    assign rs2_busy_o = pend_q[rs2_addr_i];
`else
    logic unused_sb;
    assign unused_sb  = ^{issue_en_i, issue_addr_i, flush_i, rs1_addr_i, rs2_addr_i};
    assign rs1_busy_o = 1'b0;
    assign rs2_busy_o = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
`ifdef WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        flush = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy, rs2_busy;
    int          checks = 0;
    int          failures = 0;

    regfile_wb_arbiter_if #(.NREQ(2)) wb ();

    regfile_wb_arbiter #(.NREQ(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb           (wb.slave),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rs1_busy_o   (rs1_busy),
        .rs2_busy_o   (rs2_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        wb.req_valid   = v;
        wb.req_addr[0] = a0;
        wb.req_data[0] = d0;
        wb.req_addr[1] = a1;
        wb.req_data[1] = d1;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [1:0]  exp_ready;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // contention from reset: requester 0 first, then alternate
        vecs[0] = '{2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b01, 1'b1, 5'd1, 32'h11};
        vecs[1] = '{2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b10, 1'b1, 5'd2, 32'h22};
        vecs[2] = '{2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b01, 1'b1, 5'd1, 32'h11};
        vecs[3] = '{2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b10, 1'b1, 5'd2, 32'h22};
        // single request, then idle holds address/data with rd_en low
        vecs[4] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd5, 32'hDEADBEEF};
        // x0 write: handshake, no enable
        vecs[6] = '{2'b10, 5'd0, 32'h0, 5'd0, 32'h12345678, 2'b10, 1'b0, 5'd0, 32'h12345678};
        // requester 1 alone again even though it was last granted
        vecs[7] = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 2'b10, 1'b1, 5'd9, 32'h99};
        vecs[8] = '{2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 2'b01, 1'b1, 5'd3, 32'h33};
        vecs[9] = '{2'b10, 5'd0, 32'h0, 5'd4, 32'h44, 2'b10, 1'b1, 5'd4, 32'h44};

        drive(2'b00, '0, '0, '0, '0);
        #2;
        chk("reset_rd_en", {31'd0, wb.rd_en}, 32'd0);
        chk("reset_rd_addr", {27'd0, wb.rd_addr}, 32'd0);
        chk("reset_ready", {30'd0, wb.req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            #1;
            chk($sformatf("v%0d_ready", i), {30'd0, wb.req_ready}, {30'd0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rd_en", i), {31'd0, wb.rd_en}, {31'd0, vecs[i].exp_en});
            chk($sformatf("v%0d_rd_addr", i), {27'd0, wb.rd_addr}, {27'd0, vecs[i].exp_addr});
            chk($sformatf("v%0d_rd_data", i), wb.rd_data, vecs[i].exp_data);
        end

        // scoreboard: issue x7, commit, re-issue on commit edge, commit again
        @(negedge clk);
        drive(2'b00, '0, '0, '0, '0);
        issue_en = 1'b1; issue_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
        @(posedge clk); #1;
        chk("sb_issue_x7", {31'd0, rs1_busy}, {31'd0, SB});
        chk("sb_x0_busy", {31'd0, rs2_busy}, 32'd0);
        @(negedge clk);
        issue_en = 1'b0;
        drive(2'b01, 5'd7, 32'h77, '0, '0);
        @(posedge clk); #1;
        chk("sb_wr7_en", {31'd0, wb.rd_en}, 32'd1);
        chk("sb_busy_during_wr", {31'd0, rs1_busy}, {31'd0, SB});
        @(negedge clk);
        drive(2'b00, '0, '0, '0, '0);
        issue_en = 1'b1; issue_addr = 5'd7;
        @(posedge clk); #1;
        chk("sb_set_wins", {31'd0, rs1_busy}, {31'd0, SB});
        @(negedge clk);
        issue_en = 1'b0;
        drive(2'b01, 5'd7, 32'h78, '0, '0);
        @(posedge clk); #1;
        chk("sb_busy_rd_en", {31'd0, rs1_busy}, {31'd0, SB});
        @(negedge clk);
        drive(2'b00, '0, '0, '0, '0);
        @(posedge clk); #1;
        chk("sb_busy_cleared", {31'd0, rs1_busy}, 32'd0);

        // flush: x3 and x9 pending, then flush
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd3; rs1_addr = 5'd3; rs2_addr = 5'd9;
        @(negedge clk);
        issue_addr = 5'd9;
        @(posedge clk); #1;
        chk("fl_pend3", {31'd0, rs1_busy}, {31'd0, SB});
        chk("fl_pend9", {31'd0, rs2_busy}, {31'd0, SB});
        @(negedge clk);
        issue_en = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        chk("fl_clr3", {31'd0, rs1_busy}, 32'd0);
        chk("fl_clr9", {31'd0, rs2_busy}, 32'd0);
        // flush with a simultaneous issue of x9
        @(negedge clk);
        flush = 1'b0; issue_en = 1'b1; issue_addr = 5'd3;
        @(negedge clk);
        flush = 1'b1; issue_addr = 5'd9;
        @(posedge clk); #1;
        chk("fl_iss_clr3", {31'd0, rs1_busy}, 32'd0);
        chk("fl_iss_set9", {31'd0, rs2_busy}, {31'd0, SB});

        // mid-write asynchronous reset
        @(negedge clk);
        flush = 1'b0; issue_en = 1'b0;
        drive(2'b01, 5'd6, 32'h66, '0, '0);
        @(posedge clk); #1;
        chk("mr_pre_en", {31'd0, wb.rd_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_rd_en", {31'd0, wb.rd_en}, 32'd0);
        chk("mr_rd_addr", {27'd0, wb.rd_addr}, 32'd0);
        chk("mr_rd_data", wb.rd_data, 32'd0);
        chk("mr_ready", {30'd0, wb.req_ready}, 32'd0);
        chk("mr_busy", {31'd0, rs2_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        #1;
        chk("mr_ptr_prio0", {30'd0, wb.req_ready}, 32'd1);
        @(posedge clk); #1;
        drive(2'b00, '0, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
